// File: rtl/output_port_fifo_if.sv
// W-bus consumer port bundle: LO strobe and W bus in, head entry and status out.
// No logic inside; pure signal grouping for the output port FIFO.
// Master drives strobe/bus/ready/clear; slave (the FIFO) drives data and flags.
interface output_port_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    logic                     lo;
    logic [DATA_W-1:0]        w_bus;
    logic                     ovf_clr;
    logic                     out_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;

    modport master (
        output lo, w_bus, ovf_clr, out_ready,
        input  out_valid, out_data, full, empty, count, overflow
    );

    modport slave (
        input  lo, w_bus, ovf_clr, out_ready,
        output out_valid, out_data, full, empty, count, overflow
    );
endinterface

// File: rtl/output_port_fifo.sv
// Output port FIFO: captures the W bus on each LO strobe into a FWFT queue for a peripheral.
// Latency: a pushed entry shows on out_data/out_valid one cycle after the LO edge when empty.
// Backpressure: out_ready gates pops; full blocks pushes unless a pop frees a slot, dropped LOs set sticky overflow.
module output_port_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    output_port_fifo_if.slave  port
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_nxt;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] out_data_nxt;
    logic              overflow_q;
    logic              push;
    logic              pop;
    logic              full_w;
    logic              empty_w;
    logic              drop;

    // Flags decode the registered count so they follow an async reset immediately.
    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CNT_W'(DEPTH));
    assign pop     = !empty_w && port.out_ready;
    assign push    = port.lo && (!full_w || pop);
    assign drop    = port.lo && full_w && !pop;

    assign port.out_valid = !empty_w;
    assign port.empty     = empty_w;
    assign port.full      = full_w;
    assign port.count     = count_q;
    assign port.out_data  = out_data_q;
    assign port.overflow  = overflow_q;

    // Next read pointer, count and registered head value; a push into a slot that
    // becomes the head this edge is forwarded straight from the bus.
    always_comb begin
        rd_ptr_nxt   = rd_ptr;
        count_nxt    = count_q;
        out_data_nxt = '0;
        if (pop) begin
            rd_ptr_nxt = rd_ptr + 1'b1;
        end
        if (push && !pop) begin
            count_nxt = count_q + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count_q - 1'b1;
        end
        if (count_nxt != '0) begin
            if (push && (rd_ptr_nxt == wr_ptr)) begin
                out_data_nxt = port.w_bus;
            end else begin
                out_data_nxt = mem[rd_ptr_nxt];
            end
        end
    end

    // Storage array: written on push only, deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= port.w_bus;
        end
    end

    // Pointers, count, head register and sticky overflow (set wins over clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            out_data_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr     <= rd_ptr_nxt;
            count_q    <= count_nxt;
            out_data_q <= out_data_nxt;
            overflow_q <= drop || (overflow_q && !port.ovf_clr);
        end
    end
endmodule

// File: tb/tb_output_port_fifo.sv
// Bench for output_port_fifo: directed scenarios plus a randomized run against a queue model.
// Inputs change just after the falling edge; outputs are sampled there too.
// Expected data comes from a scoreboard queue updated at each rising edge.
module tb_output_port_fifo;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    output_port_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    output_port_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .port  (bus)
    );

    int                n_checks = 0;
    int                n_fail   = 0;
    logic [DATA_W-1:0] sb_q [$];
    logic              m_ovf    = 1'b0;
    logic              pop_seen = 1'b0;
    logic [DATA_W-1:0] pop_got  = '0;
    logic [DATA_W-1:0] pop_exp  = '0;

    // An undefined W bus while LO is asserted is a system error.
    always @(posedge clk) begin
        if (rst_n && bus.lo === 1'b1) begin
            assert (!$isunknown(bus.w_bus))
            else $error("FAIL w_bus_unknown: got %h while lo=1", bus.w_bus);
        end
    end

    task automatic drive(input logic lo_i, input logic [DATA_W-1:0] w_i,
                         input logic rdy_i, input logic clr_i);
        bus.lo        = lo_i;
        bus.w_bus     = w_i;
        bus.out_ready = rdy_i;
        bus.ovf_clr   = clr_i;
    endtask

    // One clock: record what the peripheral takes, then advance the model.
    task automatic clk_step();
        logic              m_full;
        logic              m_pop;
        logic              m_push;
        logic              lo_s;
        logic              clr_s;
        logic [DATA_W-1:0] w_s;
        lo_s     = bus.lo;
        clr_s    = bus.ovf_clr;
        w_s      = bus.w_bus;
        m_full   = (sb_q.size() == DEPTH);
        m_pop    = (sb_q.size() != 0) && bus.out_ready;
        m_push   = lo_s && (!m_full || m_pop);
        pop_seen = m_pop;
        pop_got  = bus.out_data;
        pop_exp  = m_pop ? sb_q[0] : '0;
        @(posedge clk);
        if (m_pop) void'(sb_q.pop_front());
        if (m_push) sb_q.push_back(w_s);
        m_ovf = (lo_s && m_full && !m_pop) || (m_ovf && !clr_s);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.count !== '0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", bus.count); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL rst_data: got %h want 00", bus.out_data); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b want 1", bus.empty); end
        n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b want 0", bus.full); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", bus.overflow); end
        rst_n = 1'b1;
        // Build count=3 with overflow set, then reset between edges.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, DATA_W'(8'h30 + i), 1'b0, 1'b0);
            clk_step();
        end
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        clk_step();
        drive(1'b0, '0, 1'b1, 1'b0);
        clk_step();
        drive(1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (int'(bus.count) !== 3 || bus.overflow !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_state: got count=%0d ovf=%b want 3/1", bus.count, bus.overflow);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.count !== '0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", bus.count); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL midrst_data: got %h want 00", bus.out_data); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL midrst_ovf: got %b want 0", bus.overflow); end
        sb_q.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        drive(1'b1, 8'h5A, 1'b0, 1'b0);
        clk_step();
        drive(1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", bus.out_valid); end
        n_checks++; if (bus.out_data !== 8'h5A) begin n_fail++; $display("FAIL single_data: got %h want 5a", bus.out_data); end
        n_checks++; if (int'(bus.count) !== 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", bus.count); end
        drive(1'b0, '0, 1'b1, 1'b0);
        clk_step();
        drive(1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (!pop_seen || pop_got !== pop_exp) begin
            n_fail++; $display("FAIL single_pop: got %h want %h (model pop=%b)", pop_got, pop_exp, pop_seen);
        end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_fill_order();
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < DEPTH; i++) begin
                drive(1'b1, DATA_W'(i + 1), 1'b0, 1'b0);
                clk_step();
            end
            drive(1'b0, '0, 1'b0, 1'b0);
            n_checks++; if (bus.full !== 1'b1 || int'(bus.count) !== DEPTH) begin
                n_fail++; $display("FAIL fill_full rep%0d: got full=%b count=%0d want 1/4", rep, bus.full, bus.count);
            end
            for (int i = 0; i < DEPTH; i++) begin
                drive(1'b0, '0, 1'b1, 1'b0);
                clk_step();
                n_checks++; if (pop_got !== DATA_W'(i + 1) || pop_got !== pop_exp) begin
                    n_fail++; $display("FAIL fill_order rep%0d idx%0d: got %h want %h", rep, i, pop_got, pop_exp);
                end
            end
            drive(1'b0, '0, 1'b0, 1'b0);
            n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL fill_drained rep%0d: got empty=%b want 1", rep, bus.empty); end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, DATA_W'(8'h10 + i), 1'b0, 1'b0);
            clk_step();
        end
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        clk_step();
        drive(1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", bus.overflow); end
        n_checks++; if (int'(bus.count) !== DEPTH || bus.out_data !== 8'h10) begin
            n_fail++; $display("FAIL ovf_unchanged: got count=%0d head=%h want 4/10", bus.count, bus.out_data);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        clk_step();
        drive(1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b want 0", bus.overflow); end
        drive(1'b1, 8'hEE, 1'b0, 1'b1);
        clk_step();
        drive(1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (bus.overflow !== 1'b1 || bus.overflow !== m_ovf) begin
            n_fail++; $display("FAIL ovf_set_dominant: got %b want 1", bus.overflow);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        clk_step();
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_simultaneous();
        logic [DATA_W-1:0] last;
        last = '0;
        drive(1'b1, 8'hAA, 1'b1, 1'b0);
        clk_step();
        drive(1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (pop_got !== 8'h10) begin n_fail++; $display("FAIL simul_pop: got %h want 10", pop_got); end
        n_checks++; if (int'(bus.count) !== DEPTH || bus.overflow !== 1'b0) begin
            n_fail++; $display("FAIL simul_state: got count=%0d ovf=%b want 4/0", bus.count, bus.overflow);
        end
        n_checks++; if (bus.out_data !== 8'h11) begin n_fail++; $display("FAIL simul_head: got %h want 11", bus.out_data); end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            clk_step();
            n_checks++; if (pop_got !== pop_exp) begin n_fail++; $display("FAIL simul_drain idx%0d: got %h want %h", i, pop_got, pop_exp); end
            last = pop_got;
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (last !== 8'hAA) begin n_fail++; $display("FAIL simul_tail: got %h want aa", last); end
    endtask

    task automatic test_empty_push_pop();
        drive(1'b1, 8'h3C, 1'b1, 1'b0);
        clk_step();
        drive(1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (bus.out_valid !== 1'b1 || int'(bus.count) !== 1) begin
            n_fail++; $display("FAIL emptypp_state: got valid=%b count=%0d want 1/1", bus.out_valid, bus.count);
        end
        n_checks++; if (bus.out_data !== 8'h3C) begin n_fail++; $display("FAIL emptypp_data: got %h want 3c", bus.out_data); end
        drive(1'b0, '0, 1'b1, 1'b0);
        clk_step();
        drive(1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (pop_got !== pop_exp || bus.empty !== 1'b1) begin
            n_fail++; $display("FAIL emptypp_drain: got %h empty=%b want %h/1", pop_got, bus.empty, pop_exp);
        end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] head;
        for (int c = 0; c < 2000; c++) begin
            drive(($urandom_range(0, 9) < 6), DATA_W'($urandom), ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 15) == 0));
            clk_step();
            if (pop_seen) begin
                n_checks++; if (pop_got !== pop_exp) begin n_fail++; $display("FAIL rnd_pop c%0d: got %h want %h", c, pop_got, pop_exp); end
            end
            head = (sb_q.size() != 0) ? sb_q[0] : '0;
            n_checks++; if (int'(bus.count) !== sb_q.size()) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, bus.count, sb_q.size()); end
            n_checks++; if (int'(bus.count) > DEPTH) begin n_fail++; $display("FAIL rnd_count_max c%0d: got %0d want <=4", c, bus.count); end
            n_checks++; if (bus.out_data !== head) begin n_fail++; $display("FAIL rnd_head c%0d: got %h want %h", c, bus.out_data, head); end
            n_checks++; if (bus.out_valid !== (sb_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b", c, bus.out_valid); end
            n_checks++; if (bus.full !== (sb_q.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_full c%0d: got %b", c, bus.full); end
            n_checks++; if (bus.overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf c%0d: got %b want %b", c, bus.overflow, m_ovf); end
        end
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0);
        test_reset();
        test_single();
        test_fill_order();
        test_overflow();
        test_simultaneous();
        test_empty_push_pop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
